// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit hold/shift-right/shift-left/load register with serial taps at both ends
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset, loads RESET_VAL
//   en      clock enable, 0 holds q
//   mode    00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin_r   serial in at the MSB on shift right
//   sin_l   serial in at the LSB on shift left
//   d       parallel load data
//   rot     rotate select for the shift modes (present only with USR_ROTATE_EN)
//   q       register contents
//   sout_r  q[0]
//   sout_l  q[WIDTH-1]
// Optional feature macro: USR_ROTATE_EN
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
`ifdef USR_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l
);
  logic [WIDTH-1:0] r_q;
  logic             w_in_r;
  logic             w_in_l;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_next;
`ifdef USR_ROTATE_EN
  // Rotation feeds the opposite end of q back in place of the serial input.
  assign w_in_r = rot ? r_q[0] : sin_r;
  assign w_in_l = rot ? r_q[WIDTH-1] : sin_l;
`else
  assign w_in_r = sin_r;
  assign w_in_l = sin_l;
`endif
  // A one-bit register has no retained bits to shift, so it just takes the entering bit.
  if (WIDTH == 1) begin : g_w1
    assign w_shr = w_in_r;
    assign w_shl = w_in_l;
  end else begin : g_wn
    assign w_shr = {w_in_r, r_q[WIDTH-1:1]};
    assign w_shl = {r_q[WIDTH-2:0], w_in_l};
  end
  always_comb begin
    w_next = mode == 2'b11 ? d : mode == 2'b10 ? w_shl : mode == 2'b01 ? w_shr : r_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_q <= RESET_VAL;
    else if (en) r_q <= w_next;
  end
  assign q      = r_q;
  assign sout_r = r_q[0];
  assign sout_l = r_q[WIDTH-1];
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed self-checking bench for universal_shift_reg
module tb_universal_shift_reg;
  logic       clk = 0;
  logic       rst_n, en, sin_r, sin_l, rot;
  logic [1:0] mode;
  logic [7:0] d, q, exp_q;
  logic       sout_r, sout_l, q1, sr1, sl1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .d(d),
`ifdef USR_ROTATE_EN
    .rot(rot),
`endif
    .q(q), .sout_r(sout_r), .sout_l(sout_l));
  universal_shift_reg #(.WIDTH(1), .RESET_VAL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .d(d[0]),
`ifdef USR_ROTATE_EN
    .rot(rot),
`endif
    .q(q1), .sout_r(sr1), .sout_l(sl1));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask
  initial begin
    rst_n = 0; en = 1; mode = 2'b11; d = 8'hFF; sin_r = 0; sin_l = 0; rot = 0;
    step(); step();
    chk("rst_q", q, 8'hA5);
    chk("rst_sout_r", {7'd0, sout_r}, 8'd1);
    chk("rst_sout_l", {7'd0, sout_l}, 8'd1);
    chk("w1_rst_q", {7'd0, q1}, 8'd1);
    rst_n = 1;
    step();
    chk("release_load", q, 8'hFF);
    d = 8'h3C;
    step();
    chk("load_3c", q, 8'h3C);
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_mode", q, 8'h3C);
    end
    en = 0; mode = 2'b11; d = 8'h00;
    step();
    chk("hold_en0_load", q, 8'h3C);
    mode = 2'b01; sin_r = 1;
    step();
    chk("hold_en0_shift", q, 8'h3C);
    en = 1; mode = 2'b11; d = 8'h81; sin_r = 0;
    step();
    chk("load_81", q, 8'h81);
    mode = 2'b01;
    exp_q = 8'h81;
    for (int i = 0; i < 8; i++) begin
      chk("shr_sout_r", {7'd0, sout_r}, {7'd0, exp_q[0]});
      step();
      exp_q = exp_q >> 1;
      chk("shr_q", q, exp_q);
    end
    chk("shr_end", q, 8'h00);
    mode = 2'b10; sin_l = 1;
    exp_q = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk("shl_sout_l_pre", {7'd0, sout_l}, 8'd0);
      step();
      exp_q = {exp_q[6:0], 1'b1};
      chk("shl_q", q, exp_q);
    end
    chk("shl_end", q, 8'hFF);
    chk("shl_sout_l", {7'd0, sout_l}, 8'd1);
    mode = 2'b11; d = 8'h0F; sin_l = 0;
    step();
    mode = 2'b01; sin_r = 1;
    step();
    chk("mid_shr1", q, 8'h87);
    step();
    chk("mid_shr2", q, 8'hC3);
    rst_n = 0;
    step();
    chk("mid_rst", q, 8'hA5);
    rst_n = 1; sin_r = 0;
    step();
    chk("post_rst_shr", q, 8'h52);
    chk("w1_shr_q", {7'd0, q1}, 8'd0);
    chk("w1_shr_sout_l", {7'd0, sl1}, 8'd0);
    mode = 2'b10; sin_l = 1;
    step();
    chk("w1_shl_q", {7'd0, q1}, 8'd1);
    chk("w1_shl_sout_r", {7'd0, sr1}, 8'd1);
    chk("w1_shl_sout_l", {7'd0, sl1}, 8'd1);
`ifdef USR_ROTATE_EN
    mode = 2'b11; d = 8'h81;
    step();
    rot = 1; mode = 2'b01; sin_r = 0;
    step();
    chk("rot_r", q, 8'hC0);
    mode = 2'b10; sin_l = 0;
    step();
    chk("rot_l1", q, 8'h81);
    step();
    chk("rot_l2", q, 8'h03);
    rot = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
